// File: rtl/sop_sweep_pkg.sv
// rtl/sop_sweep_pkg.sv - shared types and defaults for the SOP equivalence sweeper
package sop_sweep_pkg;

   // Default number of function inputs; the truth-table depth is 2**NUM_VARS.
   localparam int NUM_VARS_DEF = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } sweep_state_t;

endpackage

// File: rtl/sop_equiv_sweeper_if.sv
// rtl/sop_equiv_sweeper_if.sv - control, golden-table and function-under-test signal bundle
interface sop_equiv_sweeper_if
   import sop_sweep_pkg::*;
#(
   parameter int NUM_VARS = NUM_VARS_DEF
);
   localparam int DEPTH = 2**NUM_VARS;

   logic                start;
   logic                stop_on_fail;
   logic [DEPTH-1:0]    on_set;
   logic [DEPTH-1:0]    dc_set;
   logic [NUM_VARS-1:0] x_out;
   logic                f_in;
   logic                busy;
   logic                done;
   logic                pass;
   logic [NUM_VARS:0]   fail_count;
   logic                first_fail_vld;
   logic [NUM_VARS-1:0] first_fail_idx;

   // Requester side: launches sweeps, supplies the golden tables and the function output.
   modport master (
      output start, stop_on_fail, on_set, dc_set, f_in,
      input  x_out, busy, done, pass, fail_count, first_fail_vld, first_fail_idx
   );

   // Sweeper side.
   modport slave (
      input  start, stop_on_fail, on_set, dc_set, f_in,
      output x_out, busy, done, pass, fail_count, first_fail_vld, first_fail_idx
   );

endinterface

// File: rtl/sop_sweep_cmp.sv
// rtl/sop_sweep_cmp.sv - sample stage plus mismatch count and first-failure tracking
module sop_sweep_cmp
   import sop_sweep_pkg::*;
#(
   parameter int NUM_VARS = NUM_VARS_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                capture,
   input  logic                evaluate,
   input  logic [NUM_VARS-1:0] idx,
   input  logic                f_in,
   input  logic                on_bit,
   input  logic                dc_bit,
   output logic                mismatch,
   output logic [NUM_VARS:0]   fail_count,
   output logic                first_fail_vld,
   output logic [NUM_VARS-1:0] first_fail_idx
);

   logic                vld_q;
   logic [NUM_VARS-1:0] idx_q;
   logic                f_q;
   logic                on_q;
   logic                dc_q;

   // Register the function output together with its golden bits so the
   // combinational f_in path is cut before the comparison.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= 1'b0;
         idx_q <= '0;
         f_q   <= 1'b0;
         on_q  <= 1'b0;
         dc_q  <= 1'b0;
      end else begin
         vld_q <= capture;
         idx_q <= idx;
         f_q   <= f_in;
         on_q  <= on_bit;
         dc_q  <= dc_bit;
      end
   end

   // A staged sample left in flight after an early stop is masked by evaluate.
   assign mismatch = evaluate & vld_q & ~dc_q & (f_q ^ on_q);

   // Count every mismatch and remember where the first one happened.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         fail_count     <= '0;
         first_fail_vld <= 1'b0;
         first_fail_idx <= '0;
      end else if (mismatch) begin
         fail_count <= fail_count + 1'b1;
         if (!first_fail_vld) begin
            first_fail_vld <= 1'b1;
            first_fail_idx <= idx_q;
         end
      end
   end

endmodule

// File: rtl/sop_equiv_sweeper.sv
// rtl/sop_equiv_sweeper.sv - exhaustive minterm sweep against a golden on-set/don't-care table
module sop_equiv_sweeper
   import sop_sweep_pkg::*;
#(
   parameter int NUM_VARS = NUM_VARS_DEF
) (
   input logic               clk,
   input logic               rst,
   sop_equiv_sweeper_if.slave bus
);

   localparam int DEPTH = 2**NUM_VARS;

   sweep_state_t        state;
   sweep_state_t        state_nxt;
   logic [NUM_VARS:0]   idx;
   logic [NUM_VARS:0]   idx_inc;
   logic [NUM_VARS-1:0] x_cur;
   logic [DEPTH-1:0]    on_q;
   logic [DEPTH-1:0]    dc_q;
   logic                stop_q;
   logic                res_vld;
   logic                accept;
   logic                capture;
   logic                evaluate;
   logic                mismatch;
   logic [NUM_VARS:0]   fail_count;
   logic                first_fail_vld;
   logic [NUM_VARS-1:0] first_fail_idx;

   assign accept   = (state == IDLE) && bus.start;
   assign capture  = (state == SWEEP);
   assign evaluate = (state == SWEEP) || (state == DRAIN);

   // The extra counter bit carries out exactly when the last minterm is on x_out.
   assign idx_inc = idx + 1'b1;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state and the minterm presented to the function.
   always_comb begin
      state_nxt = state;
      x_cur     = '0;
      case (state)
         IDLE: begin
            if (bus.start) state_nxt = SWEEP;
         end
         SWEEP: begin
            x_cur = idx[NUM_VARS-1:0];
            if (stop_q && mismatch)  state_nxt = DONE;
            else if (idx_inc[NUM_VARS]) state_nxt = DRAIN;
         end
         DRAIN: begin
            x_cur     = idx[NUM_VARS-1:0];
            state_nxt = DONE;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Minterm counter: restarts on an accepted start, holds on the last minterm for DRAIN.
   always_ff @(posedge clk) begin
      if (rst || accept) idx <= '0;
      else if (state == SWEEP && !idx_inc[NUM_VARS]) idx <= idx_inc;
   end

   // Snapshot the golden tables and the stop mode so callers may change them mid-sweep.
   always_ff @(posedge clk) begin
      if (rst) begin
         on_q   <= '0;
         dc_q   <= '0;
         stop_q <= 1'b0;
      end else if (accept) begin
         on_q   <= bus.on_set;
         dc_q   <= bus.dc_set;
         stop_q <= bus.stop_on_fail;
      end
   end

   // Result-valid flag keeps pass meaningful from done until the next start.
   always_ff @(posedge clk) begin
      if (rst || accept)      res_vld <= 1'b0;
      else if (state == DONE) res_vld <= 1'b1;
   end

   sop_sweep_cmp #(
      .NUM_VARS(NUM_VARS)
   ) u_cmp (
      .clk           (clk),
      .rst           (rst),
      .clear         (accept),
      .capture       (capture),
      .evaluate      (evaluate),
      .idx           (x_cur),
      .f_in          (bus.f_in),
      .on_bit        (on_q[x_cur]),
      .dc_bit        (dc_q[x_cur]),
      .mismatch      (mismatch),
      .fail_count    (fail_count),
      .first_fail_vld(first_fail_vld),
      .first_fail_idx(first_fail_idx)
   );

   assign bus.x_out          = x_cur;
   assign bus.busy           = (state == SWEEP) || (state == DRAIN);
   assign bus.done           = (state == DONE);
   assign bus.pass           = ((state == DONE) || res_vld) && (fail_count == '0);
   assign bus.fail_count     = fail_count;
   assign bus.first_fail_vld = first_fail_vld;
   assign bus.first_fail_idx = first_fail_idx;

endmodule
